// File: rtl/operand_sel_pipe.sv
// operand_sel_pipe: pipelined ALU operand-B select.
// Picks one of NREG register operands or a zero/sign-extended immediate.
// The result is registered behind a valid/ready handshake.
// Build option: define OPSEL_SKID_EN to add a skid register. With it, in_ready
// becomes a pure register output and sustains full throughput under back-pressure.
//
// Handshake: a beat moves on a rising edge where valid && ready. The producer
// holds the beat stable until that edge. out_data/out_is_imm/sel_err stay
// stable while out_valid && !out_ready.
module operand_sel_pipe #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 4,
  parameter int NREG   = 2,
  parameter int SEL_W  = $clog2(NREG + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NREG*DATA_W-1:0] reg_srcs,
  input  logic [IMM_W-1:0]       imm,
  input  logic                   sext,
  input  logic [SEL_W-1:0]       sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_is_imm,
  output logic                   sel_err,
  output logic [1:0]             dbg_state_o
);

  // A beat is packed as {sel_err, is_imm, data}.
  localparam int BEAT_W = DATA_W + 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   out_q, out_d;
  logic [BEAT_W-1:0]   beat_in;
  logic [DATA_W-1:0]   imm_ext;
  logic [DATA_W-1:0]   reg_data;
  logic                acc;
  logic                dq;

`ifdef OPSEL_SKID_EN
  logic [BEAT_W-1:0]   skid_q, skid_d;
  logic                in_ready_q;
`else
  logic                ready_en_q;
`endif

  // Immediate extension; at full width the field passes through untouched.
  generate
    if (IMM_W == DATA_W) begin : g_imm_full
      assign imm_ext = imm;
    end else begin : g_imm_ext
      assign imm_ext = {{(DATA_W-IMM_W){sext & imm[IMM_W-1]}}, imm};
    end
  endgenerate

  // Operand select: register source, immediate, or a zero beat flagged as illegal.
  always_comb begin
    reg_data = '0;
    for (int k = 0; k < NREG; k++) begin
      if (sel == SEL_W'(k)) reg_data = reg_srcs[k*DATA_W +: DATA_W];
    end
    if (sel < SEL_W'(NREG)) begin
      beat_in = {1'b0, 1'b0, reg_data};
    end else if (sel == SEL_W'(NREG)) begin
      beat_in = {1'b0, 1'b1, imm_ext};
    end else begin
      beat_in = {1'b1, 1'b0, {DATA_W{1'b0}}};
    end
  end

`ifdef OPSEL_SKID_EN
  assign in_ready = in_ready_q;
`else
  // Gated until the first edge after reset so a beat seen while reset releases is refused.
  assign in_ready = ready_en_q && (!out_valid || out_ready);
`endif

  assign acc = in_valid && in_ready;
  assign dq  = out_valid && out_ready;

  // Next-state and storage steering for the output (and skid) registers.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
`ifdef OPSEL_SKID_EN
    skid_d  = skid_q;
`endif
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          out_d   = beat_in;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (acc && dq) begin
          out_d = beat_in;
`ifdef OPSEL_SKID_EN
        end else if (acc) begin
          skid_d  = beat_in;
          state_d = ST_TWO;
`else
        end else if (acc) begin
          out_d = beat_in;
`endif
        end else if (dq) begin
          state_d = ST_EMPTY;
        end
      end
`ifdef OPSEL_SKID_EN
      ST_TWO: begin
        if (dq) begin
          out_d   = skid_q;
          state_d = ST_ONE;
        end
      end
`endif
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // State and beat registers; reset discards every held beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      out_q      <= '0;
`ifdef OPSEL_SKID_EN
      skid_q     <= '0;
      in_ready_q <= 1'b0;
`else
      ready_en_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
`ifdef OPSEL_SKID_EN
      skid_q     <= skid_d;
      in_ready_q <= (state_d != ST_TWO);
`else
      ready_en_q <= 1'b1;
`endif
    end
  end

  assign out_valid   = (state_q != ST_EMPTY);
  assign out_data    = out_q[DATA_W-1:0];
  assign out_is_imm  = out_q[DATA_W];
  assign sel_err     = out_q[DATA_W+1];
  assign dbg_state_o = state_q;

endmodule
